// File: rtl/instr_queue_pkg.sv
// Shared constants and types for the instruction prefetch queue.
// Stands in for the shared word/instruction widths and the default queue depth.
package instr_queue_pkg;

    localparam int unsigned WORD_W            = 32;
    localparam int unsigned INSTR_LEN         = 32;
    localparam int unsigned INSTR_QUEUE_DEPTH = 4;

    typedef struct packed {
        logic [WORD_W-1:0]    pc;
        logic [INSTR_LEN-1:0] instr;
    } iq_entry_t;

endpackage

// File: rtl/queue_ram.sv
// Storage array for the instruction queue: one synchronous write port and
// one asynchronous read port. Contents are deliberately not reset.
module queue_ram #(
    parameter  int unsigned DEPTH  = 4,
    parameter  int unsigned DATA_W = 64,
    localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/instr_queue.sv
// Instruction prefetch queue between Fetch and Decode, flushed on a taken branch.
// Define INSTR_QUEUE_BYPASS_EN for a zero-latency in->out path on an empty queue.
module instr_queue
    import instr_queue_pkg::*;
#(
    parameter  int unsigned DEPTH  = INSTR_QUEUE_DEPTH,
    localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WORD_W-1:0]    in_pc,
    input  logic [INSTR_LEN-1:0] in_instr,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WORD_W-1:0]    out_pc,
    output logic [INSTR_LEN-1:0] out_instr,
    output logic [ADDR_W:0]      count
);

    localparam logic [ADDR_W:0] FullCnt = (ADDR_W+1)'(DEPTH);

    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              full, empty, push, pop;
    iq_entry_t         wr_entry, rd_entry;
`ifdef INSTR_QUEUE_BYPASS_EN
    logic              bypass;
`endif

    always_comb begin
        full           = (count_q == FullCnt);
        empty          = (count_q == '0);
        in_ready       = !full;
        wr_entry.pc    = in_pc;
        wr_entry.instr = in_instr;
        pop            = !empty & out_ready & !flush;
`ifdef INSTR_QUEUE_BYPASS_EN
        bypass    = empty & in_valid & !flush;
        // A bypassed entry consumed this cycle is never written.
        push      = in_valid & !full & !flush & !(bypass & out_ready);
        out_valid = !empty | bypass;
        out_pc    = bypass ? in_pc : rd_entry.pc;
        out_instr = bypass ? in_instr : rd_entry.instr;
`else
        push      = in_valid & !full & !flush;
        out_valid = !empty;
        out_pc    = rd_entry.pc;
        out_instr = rd_entry.instr;
`endif
        count = count_q;
    end

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + ADDR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + ADDR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + (ADDR_W+1)'(1);
                2'b01:   count_d = count_q - (ADDR_W+1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    queue_ram #(
        .DEPTH  (DEPTH),
        .DATA_W ($bits(iq_entry_t))
    ) u_queue_ram (
        .clk_i   (clk),
        .we_i    (push),
        .waddr_i (wr_ptr_q),
        .wdata_i (wr_entry),
        .raddr_i (rd_ptr_q),
        .rdata_o (rd_entry)
    );

endmodule

// File: tb/tb_instr_queue.sv
// Self-checking bench for instr_queue: scoreboard of expected {pc, instr} pairs,
// one task per scenario. Honours INSTR_QUEUE_BYPASS_EN like the design.
module tb_instr_queue;
    import instr_queue_pkg::*;

    localparam int unsigned DEPTH = 4;

    logic                 clk       = 1'b0;
    logic                 reset     = 1'b0;
    logic                 flush     = 1'b0;
    logic                 in_valid  = 1'b0;
    logic                 out_ready = 1'b0;
    logic [WORD_W-1:0]    in_pc     = '0;
    logic [INSTR_LEN-1:0] in_instr  = '0;
    logic                 in_ready;
    logic                 out_valid;
    logic [WORD_W-1:0]    out_pc;
    logic [INSTR_LEN-1:0] out_instr;
    logic [2:0]           count;

    int n_cmp   = 0;
    int n_err   = 0;
    int m_count = 0;
    logic [WORD_W-1:0]    sb_pc[$];
    logic [INSTR_LEN-1:0] sb_instr[$];

`ifdef INSTR_QUEUE_BYPASS_EN
    localparam bit Byp = 1'b1;
`else
    localparam bit Byp = 1'b0;
`endif

    instr_queue #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_pc     (in_pc),
        .in_instr  (in_instr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_pc    (out_pc),
        .out_instr (out_instr),
        .count     (count)
    );

    always #5 clk = ~clk;

    // Inputs change 1 time unit after posedge; outputs are sampled 2 units later.
    task automatic drive(input logic iv, input logic [31:0] pc, input logic [31:0] ins,
                         input logic ordy, input logic fl);
        in_valid  = iv;
        in_pc     = pc;
        in_instr  = ins;
        out_ready = ordy;
        flush     = fl;
        #2;
    endtask

    // Update the behavioural queue model for the current inputs, then cross the edge.
    task automatic advance(output bit acc);
        bit byp_take, do_pop, do_push;
        byp_take = Byp && (m_count == 0) && in_valid && !flush && out_ready;
        acc = 1'b0;
        if (flush) begin
            sb_pc.delete();
            sb_instr.delete();
        end else if (byp_take) begin
            acc = 1'b1;
        end else begin
            do_pop  = (m_count > 0) && out_ready;
            do_push = in_valid && (m_count < DEPTH);
            if (do_pop) begin
                void'(sb_pc.pop_front());
                void'(sb_instr.pop_front());
            end
            if (do_push) begin
                sb_pc.push_back(in_pc);
                sb_instr.push_back(in_instr);
                acc = 1'b1;
            end
        end
        m_count = sb_pc.size();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        bit acc;
        n_cmp++; if (count !== 3'd0) begin n_err++; $display("FAIL rst_count: got %0d want 0", count); end
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_ovalid: got %b want 0", out_valid); end
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rst_iready: got %b want 1", in_ready); end
        @(posedge clk); #1;
        reset = 1'b1;
        drive(1'b1, 32'h10, 32'hA0, 1'b0, 1'b0); advance(acc);
        drive(1'b1, 32'h14, 32'hA4, 1'b0, 1'b0); advance(acc);
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        n_cmp++; if (count !== 3'(m_count)) begin n_err++; $display("FAIL pre_rst_count: got %0d want %0d", count, m_count); end
        // Mid-cycle reset pulse: no clock edge occurs before the checks.
        reset = 1'b0;
        #1;
        n_cmp++; if (count !== 3'd0) begin n_err++; $display("FAIL async_rst_count: got %0d want 0", count); end
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL async_rst_ovalid: got %b want 0", out_valid); end
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL async_rst_iready: got %b want 1", in_ready); end
        sb_pc.delete(); sb_instr.delete(); m_count = 0;
        @(posedge clk); #1;
        reset = 1'b1;
    endtask

    task automatic test_fill();
        bit acc;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 32'(i * 4), 32'h1100_0000 | 32'(i), 1'b0, 1'b0);
            n_cmp++;
            if (in_ready !== (i < 4)) begin
                n_err++; $display("FAIL fill_iready[%0d]: got %b want %b", i, in_ready, (i < 4));
            end
            advance(acc);
        end
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        n_cmp++; if (count !== 3'd4) begin n_err++; $display("FAIL fill_count: got %0d want 4", count); end
        n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL fill_full: got %b want 0", in_ready); end
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
            n_cmp++;
            if (out_valid !== 1'b1 || count !== 3'(4 - i) || out_pc !== 32'(i * 4)
                || out_instr !== sb_instr[0]) begin
                n_err++;
                $display("FAIL drain[%0d]: got v=%b cnt=%0d pc=%0h ins=%0h want v=1 cnt=%0d pc=%0h ins=%0h",
                         i, out_valid, count, out_pc, out_instr, 4 - i, i * 4, sb_instr[0]);
            end
            advance(acc);
        end
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        n_cmp++;
        if (count !== 3'd0 || out_valid !== 1'b0) begin
            n_err++; $display("FAIL drain_empty: got cnt=%0d v=%b want 0/0", count, out_valid);
        end
    endtask

    task automatic test_wrap();
        bit acc;
        int pushed = 0;
        int recv   = 0;
        for (int cyc = 0; cyc < 80 && recv < 10; cyc++) begin
            drive(pushed < 10, 32'(pushed * 4), 32'h1300_0000 | 32'(pushed), (cyc % 3) != 0, 1'b0);
            n_cmp++;
            if (count !== 3'(m_count)) begin
                n_err++; $display("FAIL wrap_count[%0d]: got %0d want %0d", cyc, count, m_count);
            end
            if (out_valid && out_ready) begin
                n_cmp++;
                if (out_pc !== 32'(recv * 4) || out_instr !== (32'h1300_0000 | 32'(recv))) begin
                    n_err++;
                    $display("FAIL wrap_order[%0d]: got pc=%0h ins=%0h want pc=%0h", recv, out_pc,
                             out_instr, recv * 4);
                end
                recv++;
            end
            advance(acc);
            if (acc) pushed++;
        end
        n_cmp++;
        if (recv != 10 || m_count != 0) begin
            n_err++; $display("FAIL wrap_total: got recv=%0d left=%0d want 10/0", recv, m_count);
        end
    endtask

    task automatic test_simultaneous();
        bit acc;
        drive(1'b1, 32'h100, 32'h2100, 1'b0, 1'b0); advance(acc);
        drive(1'b1, 32'h104, 32'h2104, 1'b0, 1'b0); advance(acc);
        drive(1'b1, 32'h108, 32'h2108, 1'b1, 1'b0);
        n_cmp++;
        if (count !== 3'd2 || out_pc !== 32'h100) begin
            n_err++; $display("FAIL simul_pre: got cnt=%0d pc=%0h want 2/100", count, out_pc);
        end
        advance(acc);
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        n_cmp++;
        if (count !== 3'd2 || out_pc !== 32'h104) begin
            n_err++; $display("FAIL simul_post: got cnt=%0d pc=%0h want 2/104", count, out_pc);
        end
        for (int i = 0; i < 8 && m_count > 0; i++) begin
            drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
            n_cmp++;
            if (out_valid !== 1'b1 || out_pc !== sb_pc[0]) begin
                n_err++; $display("FAIL simul_drain[%0d]: got v=%b pc=%0h want 1/%0h", i, out_valid,
                                  out_pc, sb_pc[0]);
            end
            advance(acc);
        end
    endtask

    task automatic test_flush();
        bit acc;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h200 + 32'(i * 4), 32'h3200 + 32'(i), 1'b0, 1'b0);
            advance(acc);
        end
        drive(1'b1, 32'h40, 32'h4040, 1'b0, 1'b1);
        n_cmp++; if (count !== 3'd3) begin n_err++; $display("FAIL flush_pre: got %0d want 3", count); end
        advance(acc);
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        n_cmp++;
        if (count !== 3'd0 || out_valid !== 1'b0) begin
            n_err++; $display("FAIL flush_post: got cnt=%0d v=%b want 0/0", count, out_valid);
        end
        for (int i = 0; i < 3; i++) begin
            advance(acc);
            drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
            n_cmp++;
            if (out_valid !== 1'b0) begin
                n_err++; $display("FAIL flush_idle[%0d]: got v=%b pc=%0h want v=0", i, out_valid, out_pc);
            end
        end
        // Queue must restart cleanly from zeroed pointers.
        drive(1'b1, 32'h500, 32'h5500, 1'b0, 1'b0); advance(acc);
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        n_cmp++;
        if (out_valid !== 1'b1 || out_pc !== 32'h500 || count !== 3'd1) begin
            n_err++; $display("FAIL flush_restart: got v=%b pc=%0h cnt=%0d want 1/500/1", out_valid,
                              out_pc, count);
        end
        advance(acc);
    endtask

    task automatic test_bypass();
        bit acc;
        drive(1'b1, 32'h300, 32'h8B02_0020, 1'b1, 1'b0);
`ifdef INSTR_QUEUE_BYPASS_EN
        n_cmp++;
        if (out_valid !== 1'b1 || out_instr !== 32'h8B02_0020 || out_pc !== 32'h300 || count !== 3'd0) begin
            n_err++; $display("FAIL bypass_same: got v=%b ins=%0h pc=%0h cnt=%0d want 1/8b020020/300/0",
                              out_valid, out_instr, out_pc, count);
        end
        advance(acc);
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        n_cmp++;
        if (count !== 3'd0 || out_valid !== 1'b0) begin
            n_err++; $display("FAIL bypass_after: got cnt=%0d v=%b want 0/0", count, out_valid);
        end
`else
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_err++; $display("FAIL nobypass_same: got v=%b want 0", out_valid);
        end
        advance(acc);
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        n_cmp++;
        if (out_valid !== 1'b1 || out_instr !== 32'h8B02_0020 || count !== 3'd1) begin
            n_err++; $display("FAIL nobypass_next: got v=%b ins=%0h cnt=%0d want 1/8b020020/1",
                              out_valid, out_instr, count);
        end
        advance(acc);
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        n_cmp++;
        if (count !== 3'd0) begin
            n_err++; $display("FAIL nobypass_drain: got cnt=%0d want 0", count);
        end
`endif
        advance(acc);
    endtask

    initial begin
        #3;
        test_reset();
        test_fill();
        test_wrap();
        test_simultaneous();
        test_flush();
        test_bypass();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
